clock_time_display: RTL and testbench

- Reads the binary time produced by the team's hr/min/sec time-of-day counter and drives a 6-digit multiplexed seven-segment display showing HH MM SS.
- A sequential repeated-subtraction converter turns each binary field into BCD whenever the input time changes.
- A prescaled scan counter then time-multiplexes the committed digits onto a shared segment bus.
- Sits between the time counter and the board display pins.

---
 rtl/clock_time_display_if.sv | 22 ++
 rtl/clock_time_display.sv | 226 ++++++++++++++++++++++
 tb/tb_clock_time_display.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_time_display_if.sv
// Bundle of the binary time inputs and display-side outputs of clock_time_display.
// master = time source / board side, slave = the display block itself.
interface clock_time_display_if;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] seg;
  logic [5:0] an;
  logic       busy;
  logic       bcd_valid;
  logic       range_err;

  modport master (
    output hr, min, sec,
    input  seg, an, busy, bcd_valid, range_err
  );

  modport slave (
    input  hr, min, sec,
    output seg, an, busy, bcd_valid, range_err
  );
endinterface

// File: rtl/clock_time_display.sv
// Converts binary hr/min/sec to BCD by repeated subtraction and scans the six
// committed digits (HH MM SS) onto a multiplexed seven-segment display.
module clock_time_display #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  clock_time_display_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_HR  = 3'd1,
    CONV_MIN = 3'd2,
    CONV_SEC = 3'd3,
    COMMIT   = 3'd4
  } state_t;

  localparam logic [3:0]  DASH      = 4'hA;
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 32'd1);
  localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]  AN_OFF    = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      DASH:    s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Pending digit pair {tens, ones}; an out-of-range field shows two dashes.
  function automatic logic [7:0] digit_pair(input logic inv, input logic [2:0] tens,
                                            input logic [3:0] ones);
    logic [7:0] p;
    if (inv) begin
      p = {DASH, DASH};
    end else begin
      p = {1'b0, tens, ones};
    end
    return p;
  endfunction

  state_t          state_q, state_d;
  logic [4:0]      snap_hr_q, snap_hr_d;
  logic [5:0]      snap_min_q, snap_min_d;
  logic [5:0]      snap_sec_q, snap_sec_d;
  logic [5:0]      rem_q, rem_d;
  logic [2:0]      tens_q, tens_d;
  logic [2:0]      inv_q, inv_d;
  logic [5:0][3:0] pend_q, pend_d;
  logic [5:0][3:0] disp_q, disp_d;
  logic            busy_q, busy_d;
  logic            bcd_valid_q, bcd_valid_d;
  logic            range_err_q, range_err_d;
  logic [15:0]     presc_q, presc_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [5:0]      an_q, an_d;
  logic [5:0]      an_raw_s;
  logic [3:0]      digit_s;
  logic            differs_s;

  assign differs_s = {bus.hr, bus.min, bus.sec} != {snap_hr_q, snap_min_q, snap_sec_q};

  // Converter next-state: capture, subtract-by-ten per field, commit.
  always_comb begin
    state_d     = state_q;
    snap_hr_d   = snap_hr_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    rem_d       = rem_q;
    tens_d      = tens_q;
    inv_d       = inv_q;
    pend_d      = pend_q;
    disp_d      = disp_q;
    range_err_d = range_err_q;
    case (state_q)
      IDLE: begin
        if (differs_s) begin
          snap_hr_d  = bus.hr;
          snap_min_d = bus.min;
          snap_sec_d = bus.sec;
          inv_d      = {bus.hr > 5'd23, bus.min > 6'd59, bus.sec > 6'd59};
          rem_d      = {1'b0, bus.hr};
          tens_d     = 3'd0;
          state_d    = CONV_HR;
        end else begin
          state_d    = IDLE;
        end
      end
      CONV_HR, CONV_MIN, CONV_SEC: begin
        if (rem_q >= 6'd10) begin
          rem_d  = rem_q - 6'd10;
          tens_d = tens_q + 3'd1;
        end else begin
          tens_d = 3'd0;
          case (state_q)
            CONV_HR: begin
              {pend_d[5], pend_d[4]} = digit_pair(inv_q[2], tens_q, rem_q[3:0]);
              rem_d   = snap_min_q;
              state_d = CONV_MIN;
            end
            CONV_MIN: begin
              {pend_d[3], pend_d[2]} = digit_pair(inv_q[1], tens_q, rem_q[3:0]);
              rem_d   = snap_sec_q;
              state_d = CONV_SEC;
            end
            CONV_SEC: begin
              {pend_d[1], pend_d[0]} = digit_pair(inv_q[0], tens_q, rem_q[3:0]);
              rem_d   = 6'd0;
              state_d = COMMIT;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
      COMMIT: begin
        disp_d      = pend_q;
        range_err_d = |inv_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    bcd_valid_d = (state_q == COMMIT);
  end

  // Digit select for the current scan position.
  always_comb begin
    case (idx_q)
      3'd0:    begin an_raw_s = 6'b000001; digit_s = disp_q[0]; end
      3'd1:    begin an_raw_s = 6'b000010; digit_s = disp_q[1]; end
      3'd2:    begin an_raw_s = 6'b000100; digit_s = disp_q[2]; end
      3'd3:    begin an_raw_s = 6'b001000; digit_s = disp_q[3]; end
      3'd4:    begin an_raw_s = 6'b010000; digit_s = disp_q[4]; end
      3'd5:    begin an_raw_s = 6'b100000; digit_s = disp_q[5]; end
      default: begin an_raw_s = 6'b000000; digit_s = 4'hF;      end
    endcase
  end

  // Scan prescaler, index walk (5 down to 0) and polarity-adjusted outputs.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == SCAN_LAST) begin
      presc_d = 16'd0;
      if (idx_q == 3'd0) begin
        idx_d = 3'd5;
      end else begin
        idx_d = idx_q - 3'd1;
      end
    end else begin
      presc_d = presc_q + 16'd1;
    end
    if (SEG_ACTIVE_LOW) begin
      an_d  = ~an_raw_s;
      seg_d = ~seg_decode(digit_s);
    end else begin
      an_d  = an_raw_s;
      seg_d = seg_decode(digit_s);
    end
  end

  // All state registers; reset aborts any conversion without committing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_hr_q   <= 5'd31;
      snap_min_q  <= 6'd63;
      snap_sec_q  <= 6'd63;
      rem_q       <= 6'd0;
      tens_q      <= 3'd0;
      inv_q       <= 3'd0;
      pend_q      <= '0;
      disp_q      <= '0;
      busy_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      presc_q     <= 16'd0;
      idx_q       <= 3'd5;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      state_q     <= state_d;
      snap_hr_q   <= snap_hr_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      rem_q       <= rem_d;
      tens_q      <= tens_d;
      inv_q       <= inv_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
      bcd_valid_q <= bcd_valid_d;
      range_err_q <= range_err_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_clock_time_display.sv
// Self-checking bench for clock_time_display: directed table, hand sequences for
// busy-time changes and mid-conversion reset, then random times against a model.
module tb_clock_time_display;

  localparam int SD = 4;
  typedef logic [5:0][6:0] segs_t;
  typedef struct {
    logic [4:0] hr;
    logic [5:0] mi;
    logic [5:0] se;
    int         lat;
    segs_t      segs;
    logic       rerr;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   snap_h, snap_m, snap_s;
  logic prev_rerr;
  logic [5:0] first_an;

  clock_time_display_if bus ();
  clock_time_display_if bus_n ();

  assign bus_n.hr  = bus.hr;
  assign bus_n.min = bus.min;
  assign bus_n.sec = bus.sec;

  clock_time_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  clock_time_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clock(clock), .reset(reset), .bus(bus_n.slave));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Active-low instance must always be the bitwise inverse of the active-high one.
  always @(negedge clock) begin
    chk("inv_seg", {57'd0, bus_n.seg}, {57'd0, ~bus.seg});
    chk("inv_an", {58'd0, bus_n.an}, {58'd0, ~bus.an});
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic segs_t model_segs(input int h, input int m, input int s);
    segs_t r;
    r[5] = (h > 23) ? seg_of(10) : seg_of(h / 10);
    r[4] = (h > 23) ? seg_of(10) : seg_of(h % 10);
    r[3] = (m > 59) ? seg_of(10) : seg_of(m / 10);
    r[2] = (m > 59) ? seg_of(10) : seg_of(m % 10);
    r[1] = (s > 59) ? seg_of(10) : seg_of(s / 10);
    r[0] = (s > 59) ? seg_of(10) : seg_of(s % 10);
    return r;
  endfunction

  // Lock onto the start of a scan frame, then check every cycle of every digit.
  task automatic check_display(input segs_t exp);
    logic [5:0] prev;
    int found = 0;
    prev = bus.an;
    for (int t = 0; t < 64; t++) begin
      tick();
      if (bus.an == 6'b100000 && prev == 6'b000001) begin
        found = 1;
        break;
      end
      prev = bus.an;
    end
    chk("scan_sync", 64'(found), 64'd1);
    if (found == 1) begin
      for (int i = 5; i >= 0; i--) begin
        for (int j = 0; j < SD; j++) begin
          if (!(i == 5 && j == 0)) tick();
          chk("scan_an", {58'd0, bus.an}, {58'd0, 6'b000001 << i});
          chk("scan_seg", {57'd0, bus.seg}, {57'd0, exp[i]});
        end
      end
    end
  endtask

  // First posedge is the capture edge (k=1); commit expected at k = lat+1.
  task automatic wait_commit(input int lat, input segs_t segs, input logic rerr);
    int got = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1) begin
        chk("busy_rise", {63'd0, bus.busy}, 64'd1);
        chk("rerr_hold", {63'd0, bus.range_err}, {63'd0, prev_rerr});
        first_an = bus.an;
      end
      if (bus.bcd_valid) begin
        got = k;
        break;
      end
    end
    chk("commit_latency", 64'(got), 64'(lat + 1));
    chk("range_err", {63'd0, bus.range_err}, {63'd0, rerr});
    tick();
    chk("bcd_pulse_end", {63'd0, bus.bcd_valid}, 64'd0);
    chk("busy_fall", {63'd0, bus.busy}, 64'd0);
    prev_rerr = rerr;
    check_display(segs);
  endtask

  task automatic run_vec(input int h, input int m, input int s, input int lat,
                         input segs_t segs, input logic rerr);
    @(negedge clock);
    bus.hr  = 5'(h);
    bus.min = 6'(m);
    bus.sec = 6'(s);
    snap_h = h; snap_m = m; snap_s = s;
    wait_commit(lat, segs, rerr);
  endtask

  vec_t vecs[5];

  initial begin
    int pulses, c1, c2, h, m, s;
    vecs[0] = '{hr: 5'd0,  mi: 6'd0,  se: 6'd0,  lat: 4,
                segs: {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, rerr: 1'b0};
    vecs[1] = '{hr: 5'd23, mi: 6'd59, se: 6'd59, lat: 16,
                segs: {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, rerr: 1'b0};
    vecs[2] = '{hr: 5'd25, mi: 6'd61, se: 6'd10, lat: 13,
                segs: {7'h40, 7'h40, 7'h40, 7'h40, 7'h06, 7'h3F}, rerr: 1'b1};
    vecs[3] = '{hr: 5'd9,  mi: 6'd5,  se: 6'd7,  lat: 4,
                segs: {7'h3F, 7'h6F, 7'h3F, 7'h6D, 7'h3F, 7'h07}, rerr: 1'b0};
    vecs[4] = '{hr: 5'd31, mi: 6'd0,  se: 6'd0,  lat: 7,
                segs: {7'h40, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, rerr: 1'b1};

    bus.hr = 5'd31; bus.min = 6'd63; bus.sec = 6'd63;
    snap_h = 31; snap_m = 63; snap_s = 63;
    prev_rerr = 1'b0;
    #2 reset = 1'b1;
    #10;
    chk("rst_seg", {57'd0, bus.seg}, 64'd0);
    chk("rst_an", {58'd0, bus.an}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_bcd_valid", {63'd0, bus.bcd_valid}, 64'd0);
    chk("rst_range_err", {63'd0, bus.range_err}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("first_an", {58'd0, bus.an}, 64'h20);
    chk("snapshot_equal_idle", {63'd0, bus.busy}, 64'd0);
    chk("first_seg", {57'd0, bus.seg}, 64'h3F);

    for (int i = 0; i < 5; i++) begin
      run_vec(int'(vecs[i].hr), int'(vecs[i].mi), int'(vecs[i].se),
              vecs[i].lat, vecs[i].segs, vecs[i].rerr);
    end

    // Reset while converting the minutes field of 20:45:13.
    @(negedge clock);
    bus.hr = 5'd20; bus.min = 6'd45; bus.sec = 6'd13;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_seg", {57'd0, bus.seg}, 64'd0);
    chk("mid_rst_an", {58'd0, bus.an}, 64'd0);
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rst_range_err", {63'd0, bus.range_err}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_no_pulse", {63'd0, bus.bcd_valid}, 64'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    prev_rerr = 1'b0;
    snap_h = 20; snap_m = 45; snap_s = 13;
    wait_commit(11, model_segs(20, 45, 13), 1'b0);
    chk("post_rst_first_an", {58'd0, first_an}, 64'h20);

    // 12:34:56 then 12:34:57 while still converting.
    @(negedge clock);
    bus.hr = 5'd12; bus.min = 6'd34; bus.sec = 6'd56;
    pulses = 0; c1 = 0; c2 = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (bus.bcd_valid) begin
        pulses++;
        if (c1 == 0) c1 = k; else c2 = k;
      end
      if (k == 15) chk("restart_busy", {63'd0, bus.busy}, 64'd1);
      if (k == 3) begin
        @(negedge clock);
        bus.sec = 6'd57;
      end
    end
    chk("change_pulses", 64'(pulses), 64'd2);
    chk("change_first_commit", 64'(c1), 64'd14);
    chk("change_second_commit", 64'(c2), 64'd28);
    snap_h = 12; snap_m = 34; snap_s = 57;
    prev_rerr = 1'b0;
    check_display(model_segs(12, 34, 57));

    // Random times, mostly legal, against the arithmetic model.
    for (int n = 0; n < 25; n++) begin
      h = ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0)) : int'($urandom_range(23, 0));
      m = ($urandom_range(3, 0) == 0) ? int'($urandom_range(63, 0)) : int'($urandom_range(59, 0));
      s = ($urandom_range(3, 0) == 0) ? int'($urandom_range(63, 0)) : int'($urandom_range(59, 0));
      if (h == snap_h && m == snap_m && s == snap_s) s = (s == 0) ? 1 : 0;
      run_vec(h, m, s, h / 10 + m / 10 + s / 10 + 4, model_segs(h, m, s),
              (h > 23) || (m > 59) || (s > 59));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
